// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: imem request/response, redirect/halt control and decode delivery signals
interface fetch_sequencer_if #(parameter int XLEN = 32);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            halt;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [31:0]     if_instr;
   logic            if_ready;
   logic            busy;
   modport master (
      output imem_req, imem_addr, if_valid, if_pc, if_instr, busy,
      input  imem_ack, imem_rdata, redirect_valid, redirect_pc, halt, if_ready
   );
   modport slave (
      input  imem_req, imem_addr, if_valid, if_pc, if_instr, busy,
      output imem_ack, imem_rdata, redirect_valid, redirect_pc, halt, if_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches over req/ack into a 2-entry FIFO feeding decode
module fetch_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
   input logic               clk,
   input logic               reset,
   fetch_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;
   state_t          state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt, pend, pend_nxt, rpc;
   logic [XLEN+31:0] mem [2];
   logic [1:0]      count, cnt_nxt;
   logic            wptr, rptr, push, pop, flush;
   assign rpc           = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign flush         = bus.redirect_valid;
   assign bus.imem_req  = state == REQ || state == DRAIN;
   assign bus.busy      = bus.imem_req;
   // DRAIN keeps pc untouched (target sits in pend), so the held address is still pc
   assign bus.imem_addr = pc;
   assign bus.if_valid  = count != 2'd0 && !flush;
   assign {bus.if_pc, bus.if_instr} = mem[rptr];
   assign pop           = bus.if_valid && bus.if_ready;
   assign push          = state == REQ && bus.imem_ack && !flush;
   assign cnt_nxt       = count + 2'(push) - 2'(pop);
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      pend_nxt  = pend;
      case (state)
         IDLE:
            if (flush) pc_nxt = rpc;
            else if (bus.halt) state_nxt = HALT;
            else if (cnt_nxt < 2'd2) state_nxt = REQ;
         REQ:
            if (bus.imem_ack) begin
               pc_nxt    = flush ? rpc : pc + XLEN'(4);
               state_nxt = bus.halt ? HALT : (flush || cnt_nxt < 2'd2) ? REQ : IDLE;
            end else if (flush) begin
               pend_nxt  = rpc;
               state_nxt = DRAIN;
            end
         DRAIN: begin
            pend_nxt = flush ? rpc : pend;
            if (bus.imem_ack) begin
               pc_nxt    = flush ? rpc : pend;
               state_nxt = bus.halt ? HALT : REQ;
            end
         end
         HALT:
            if (flush) pc_nxt = rpc;
            else if (!bus.halt) state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!reset) begin
         state <= IDLE;
         pc    <= RESET_VECTOR;
         pend  <= RESET_VECTOR;
         count <= '0;
         wptr  <= 1'b0;
         rptr  <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         pend  <= pend_nxt;
         count <= flush ? 2'd0 : cnt_nxt;
         wptr  <= flush ? 1'b0 : wptr ^ push;
         rptr  <= flush ? 1'b0 : rptr ^ pop;
      end
   always_ff @(posedge clk)
      if (push) mem[wptr] <= {pc, bus.imem_rdata};
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed fetch/redirect/halt/reset scenarios with hand-computed expectations
module tb_fetch_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;
   fetch_sequencer_if #(.XLEN(32)) bus ();
   fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic do_reset(input string tag);
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      #1;
      chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
      chk({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
   endtask
   initial begin
      bus.imem_ack = 1'b1;
      bus.if_ready = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;
      bus.halt = 1'b0;
      cyc();
      do_reset("rst0");
      for (int k = 0; k < 5; k++) begin
         cyc();
         #1;
         chk("t1_addr", bus.imem_addr, 32'(4 * k));
         chk("t1_valid", 32'(bus.if_valid), 32'(k > 0));
         if (k > 0) chk("t1_pc", bus.if_pc, 32'(4 * (k - 1)));
      end
      bus.if_ready = 1'b0;
      do_reset("rst2");
      cyc(); #1;
      chk("t2_addr0", bus.imem_addr, 32'h0);
      cyc(); #1;
      chk("t2_addr4", bus.imem_addr, 32'h4);
      chk("t2_pc0", bus.if_pc, 32'h0);
      cyc(); #1;
      chk("t2_full_req", 32'(bus.imem_req), 32'd0);
      cyc(); #1;
      chk("t2_full_req2", 32'(bus.imem_req), 32'd0);
      chk("t2_head", bus.if_pc, 32'h0);
      bus.if_ready = 1'b1;
      #1;
      chk("t2_pop_valid", 32'(bus.if_valid), 32'd1);
      cyc(); #1;
      chk("t2_addr8", bus.imem_addr, 32'h8);
      chk("t2_pc4", bus.if_pc, 32'h4);
      cyc(); #1;
      chk("t2_pc8", bus.if_pc, 32'h8);
      do_reset("rst3");
      cyc(); #1;
      chk("t3_addr0", bus.imem_addr, 32'h0);
      cyc(); #1;
      chk("t3_pc0", bus.if_pc, 32'h0);
      cyc();
      bus.imem_ack = 1'b0;
      #1;
      chk("t3_addr8", bus.imem_addr, 32'h8);
      chk("t3_pc4", bus.if_pc, 32'h4);
      cyc(); #1;
      chk("t3_wait_addr", bus.imem_addr, 32'h8);
      chk("t3_empty", 32'(bus.if_valid), 32'd0);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h103;
      cyc();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t3_drain_addr", bus.imem_addr, 32'h8);
      chk("t3_drain_busy", 32'(bus.busy), 32'd1);
      cyc();
      bus.imem_ack = 1'b1;
      #1;
      chk("t3_ack_addr", bus.imem_addr, 32'h8);
      chk("t3_ack_valid", 32'(bus.if_valid), 32'd0);
      cyc(); #1;
      chk("t3_new_addr", bus.imem_addr, 32'h100);
      chk("t3_dropped", 32'(bus.if_valid), 32'd0);
      cyc(); #1;
      chk("t3_first_pc", bus.if_pc, 32'h100);
      chk("t3_first_instr", bus.if_instr, 32'hDEAD_0100);
      cyc();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFC;
      #1;
      chk("t4_gate", 32'(bus.if_valid), 32'd0);
      cyc();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t4_flushed", 32'(bus.if_valid), 32'd0);
      chk("t4_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
      cyc(); #1;
      chk("t4_wrap_addr", bus.imem_addr, 32'h0);
      chk("t4_pc_top", bus.if_pc, 32'hFFFF_FFFC);
      cyc();
      bus.imem_ack = 1'b0;
      bus.halt = 1'b1;
      #1;
      chk("t5_addr4", bus.imem_addr, 32'h4);
      chk("t5_pc0", bus.if_pc, 32'h0);
      cyc();
      bus.if_ready = 1'b0;
      #1;
      chk("t5_hold_req", 32'(bus.imem_req), 32'd1);
      cyc();
      bus.imem_ack = 1'b1;
      #1;
      chk("t5_hold_addr", bus.imem_addr, 32'h4);
      cyc();
      bus.imem_ack = 1'b0;
      #1;
      chk("t5_halt_req", 32'(bus.imem_req), 32'd0);
      chk("t5_halt_busy", 32'(bus.busy), 32'd0);
      chk("t5_buffered", bus.if_pc, 32'h4);
      chk("t5_buf_valid", 32'(bus.if_valid), 32'd1);
      bus.if_ready = 1'b1;
      cyc();
      bus.halt = 1'b0;
      #1;
      chk("t5_drained", 32'(bus.if_valid), 32'd0);
      cyc(); #1;
      chk("t5_idle_req", 32'(bus.imem_req), 32'd0);
      cyc(); #1;
      chk("t5_resume", bus.imem_addr, 32'h8);
      chk("t5_resume_req", 32'(bus.imem_req), 32'd1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h200;
      cyc();
      bus.redirect_valid = 1'b0;
      #1;
      chk("t6_drain_busy", 32'(bus.busy), 32'd1);
      do_reset("t6_rst");
      bus.imem_ack = 1'b1;
      #1;
      chk("t6_stale_req", 32'(bus.imem_req), 32'd0);
      cyc(); #1;
      chk("t6_addr", bus.imem_addr, 32'h0);
      cyc(); #1;
      chk("t6_pc", bus.if_pc, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
